// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_queue
//  Description : Instruction fetch unit with a decoupled, PC-tagged prefetch
//                FIFO, credit-based request issue and branch flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue #(
    parameter int                    DATA_WIDTH  = 27,
    parameter int                    QUEUE_DEPTH = 4,
    parameter int                    PC_STEP     = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               i_Freeze,
    input  logic                               i_Branch_Taken,
    input  logic [DATA_WIDTH-1:0]              i_Branch_Address,
    output logic                               o_Imem_Req,
    output logic [DATA_WIDTH-1:0]              o_Imem_Addr,
    input  logic                               i_Imem_Valid,
    input  logic [DATA_WIDTH-1:0]              i_Imem_Data,
    output logic                               o_Valid,
    output logic [DATA_WIDTH-1:0]              o_Pc,
    output logic [DATA_WIDTH-1:0]              o_Instruction,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_Count
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int c_INF_W = $clog2(2 * QUEUE_DEPTH + 1);
    localparam int c_SUM_W = c_INF_W + 1;
    localparam logic [DATA_WIDTH-1:0] c_STEP = DATA_WIDTH'(PC_STEP);

    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0] r_ret_pc;
    logic [c_INF_W-1:0]    r_inflight;
    logic [c_INF_W-1:0]    r_discard;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [DATA_WIDTH-1:0] r_pc_mem    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_instr_mem [QUEUE_DEPTH];

    logic [c_INF_W-1:0]    w_live;
    logic [c_SUM_W-1:0]    w_credit_used;
    logic                  w_req;
    logic                  w_resp;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_head_valid;
    logic                  w_pop;
    logic [c_INF_W-1:0]    w_inflight_next;

    // Credit counts queued entries plus live requests, so a push never finds the queue full.
    assign w_live          = r_inflight - r_discard;
    assign w_credit_used   = c_SUM_W'(r_count) + c_SUM_W'(w_live);
    assign w_req           = !reset && !i_Branch_Taken && (w_credit_used < c_SUM_W'(QUEUE_DEPTH));
    assign w_resp          = i_Imem_Valid && (r_inflight != '0);
    assign w_drop          = w_resp && (r_discard != '0);
    assign w_push          = w_resp && !w_drop;
    assign w_head_valid    = (r_count != '0);
    assign w_pop           = w_head_valid && !i_Freeze;
    assign w_inflight_next = r_inflight + c_INF_W'(w_req) - c_INF_W'(w_resp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_ret_pc   <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (i_Branch_Taken) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            r_fetch_pc <= i_Branch_Address;
            r_ret_pc   <= i_Branch_Address;
            r_inflight <= w_inflight_next;
            r_discard  <= w_inflight_next;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (w_drop) begin
                r_discard <= r_discard - c_INF_W'(1);
            end
            if (w_req) begin
                r_fetch_pc <= r_fetch_pc + c_STEP;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                r_ret_pc <= r_ret_pc + c_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !i_Branch_Taken && w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_ret_pc;
            r_instr_mem[r_wr_ptr] <= i_Imem_Data;
        end
    end

    assign o_Imem_Req    = w_req;
    assign o_Imem_Addr   = r_fetch_pc;
    assign o_Valid       = !reset && w_head_valid;
    assign o_Pc          = o_Valid ? r_pc_mem[r_rd_ptr] : '0;
    assign o_Instruction = o_Valid ? r_instr_mem[r_rd_ptr] : '0;
    assign o_Count       = reset ? '0 : r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch_queue
//  Description : Self-checking bench for fetch_prefetch_queue with a pipelined
//                memory model and an epoch-based stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

    localparam int            DW        = 27;
    localparam int            QD        = 4;
    localparam logic [DW-1:0] INSTR_OFS = 27'h100;
    localparam logic [DW-1:0] PC0       = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          br;
    logic [DW-1:0] br_addr;
    logic          imem_valid;
    logic [DW-1:0] imem_data;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
    logic [2:0]    count;

    fetch_prefetch_queue #(
        .DATA_WIDTH (DW),
        .QUEUE_DEPTH(QD),
        .PC_STEP    (1),
        .RESET_PC   (PC0)
    ) dut (
        .clk             (clk),
        .reset           (rst),
        .i_Freeze        (freeze),
        .i_Branch_Taken  (br),
        .i_Branch_Address(br_addr),
        .o_Imem_Req      (imem_req),
        .o_Imem_Addr     (imem_addr),
        .i_Imem_Valid    (imem_valid),
        .i_Imem_Data     (imem_data),
        .o_Valid         (valid),
        .o_Pc            (pc),
        .o_Instruction   (instr),
        .o_Count         (count)
    );

    always #5 clk = ~clk;

    // Memory holds outstanding requests; each is tagged with the stream epoch it was issued in.
    typedef struct {
        logic [DW-1:0] addr;
        int            epoch;
        int            due;
    } mreq_t;

    mreq_t         mem[$];
    logic [DW-1:0] fifo[$];
    logic [DW-1:0] m_fetch_pc;
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            lat      = 1;
    int            epoch    = 0;

    function automatic int live_cnt();
        int n = 0;
        foreach (mem[i]) if (mem[i].epoch == epoch) n++;
        return n;
    endfunction

    function automatic logic [85:0] obs_vec();
        return {valid, count, valid ? pc : 27'd0, valid ? instr : 27'd0,
                imem_req, imem_req ? imem_addr : 27'd0};
    endfunction

    function automatic logic [85:0] exp_vec();
        logic          v;
        logic          r;
        logic [2:0]    c;
        logic [DW-1:0] hp;
        logic [DW-1:0] hi;
        if (rst) return '0;
        v  = (fifo.size() != 0);
        c  = 3'(fifo.size());
        hp = '0;
        hi = '0;
        if (v) begin
            hp = fifo[0];
            hi = fifo[0] + INSTR_OFS;
        end
        r = !br && ((fifo.size() + live_cnt()) < QD);
        return {v, c, hp, hi, r, r ? m_fetch_pc : 27'd0};
    endfunction

    task automatic prep();
        imem_valid = 1'b0;
        imem_data  = '0;
        if (!rst && mem.size() > 0 && mem[0].due == cyc) begin
            imem_valid = 1'b1;
            imem_data  = mem[0].addr + INSTR_OFS;
        end
        #2;
    endtask

    task automatic advance();
        mreq_t ent;
        logic  live_resp;
        if (rst) begin
            fifo.delete();
            mem.delete();
            m_fetch_pc = PC0;
            epoch++;
        end else begin
            live_resp = 1'b0;
            if (imem_valid) begin
                ent       = mem.pop_front();
                live_resp = (ent.epoch == epoch);
            end
            if (br) begin
                fifo.delete();
                m_fetch_pc = br_addr;
                epoch++;
            end else begin
                if (fifo.size() > 0 && !freeze) void'(fifo.pop_front());
                if (live_resp) fifo.push_back(ent.addr);
                if (imem_req) m_fetch_pc = m_fetch_pc + 27'd1;
            end
            if (imem_req) mem.push_back('{addr: imem_addr, epoch: epoch, due: cyc + lat});
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input int l);
        rst    = 1'b1;
        br     = 1'b0;
        freeze = 1'b0;
        lat    = l;
        repeat (n) begin
            prep();
            advance();
        end
        rst = 1'b0;
    endtask

    task automatic test_reset_run();
        rst = 1'b1;
        lat = 1;
        prep();
        advance();
        prep();
        checks++;
        if ({valid, count, pc, instr, imem_req} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b cnt=%0d pc=%h ins=%h req=%b exp all zero",
                     valid, count, pc, instr, imem_req);
        end
        advance();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_run_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (k == 0) begin
                checks++;
                if (imem_req !== 1'b1 || imem_addr !== PC0) begin
                    failures++;
                    $display("FAIL first_req got req=%b addr=%h exp req=1 addr=%h", imem_req, imem_addr, PC0);
                end
            end
            if (k >= 2) begin
                checks++;
                if (valid !== 1'b1 || pc !== DW'(k - 2)) begin
                    failures++;
                    $display("FAIL stream k=%0d got v=%b pc=%h exp v=1 pc=%h", k, valid, pc, DW'(k - 2));
                end
            end
            if (k == 2) begin
                checks++;
                if (instr !== 27'h100) begin
                    failures++;
                    $display("FAIL first_instr got=%h exp=%h", instr, 27'h100);
                end
            end
            advance();
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL freeze_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (valid !== 1'b1 || pc !== 27'd5) begin
                failures++;
                $display("FAIL freeze_hold i=%0d got v=%b pc=%h exp v=1 pc=5", i, valid, pc);
            end
            if (i == 5) begin
                checks++;
                if (count !== 3'd4 || imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL freeze_full got cnt=%0d req=%b exp cnt=4 req=0", count, imem_req);
                end
            end
            advance();
        end
        freeze = 1'b0;
        for (int j = 0; j < 8; j++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL unfreeze_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (valid !== 1'b1 || pc !== DW'(5 + j)) begin
                failures++;
                $display("FAIL freeze_release j=%0d got v=%b pc=%h exp pc=%h", j, valid, pc, DW'(5 + j));
            end
            advance();
        end
    endtask

    task automatic test_branch();
        br      = 1'b1;
        br_addr = 27'd20;
        prep();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL branch_cycle_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        advance();
        br = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL branch_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (k < 3) begin
                if (valid !== 1'b0) begin
                    failures++;
                    $display("FAIL branch_bubble k=%0d got v=%b exp v=0", k, valid);
                end
            end else if (valid !== 1'b1 || pc !== DW'(20 + k - 3)) begin
                failures++;
                $display("FAIL branch_stream k=%0d got v=%b pc=%h exp pc=%h", k, valid, pc, DW'(20 + k - 3));
            end
            advance();
        end
    endtask

    task automatic test_latency();
        int  n_out;
        bit  seen;
        do_reset(2, 4);
        for (int k = 0; k < 4; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL lat_fill_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
        // Four requests outstanding here, the oldest returning this very cycle.
        br      = 1'b1;
        br_addr = 27'd300;
        prep();
        advance();
        br    = 1'b0;
        n_out = 0;
        for (int j = 1; j <= 17; j++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL lat_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (j < 6) begin
                checks++;
                if (valid !== 1'b0) begin
                    failures++;
                    $display("FAIL lat_drop j=%0d got v=%b pc=%h exp v=0", j, valid, pc);
                end
            end else if (j == 6) begin
                checks++;
                if (valid !== 1'b1 || pc !== 27'd300) begin
                    failures++;
                    $display("FAIL lat_first j=%0d got v=%b pc=%h exp pc=300", j, valid, pc);
                end
            end
            if (j >= 6 && valid === 1'b1) n_out++;
            advance();
        end
        // Credit returns L+2 cycles after issue: QD entries every 6 cycles.
        checks++;
        if (n_out !== 8) begin
            failures++;
            $display("FAIL lat_throughput got=%0d exp=8 per 12 cycles", n_out);
        end
        br      = 1'b1;
        br_addr = 27'd400;
        prep();
        advance();
        br = 1'b0;
        prep();
        advance();
        br      = 1'b1;
        br_addr = 27'd500;
        prep();
        advance();
        br   = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rebranch_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (!seen && valid === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (pc !== 27'd500) begin
                    failures++;
                    $display("FAIL rebranch_first got pc=%h exp pc=500", pc);
                end
            end
            advance();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rebranch_timeout got no valid in 20 cycles exp target 500");
        end
    endtask

    task automatic test_wrap_branch_freeze();
        do_reset(2, 1);
        for (int k = 0; k < 4; k++) begin
            prep();
            advance();
        end
        br      = 1'b1;
        br_addr = 27'h7FFFFFF;
        prep();
        advance();
        br = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (valid !== 1'b1 || pc !== (k == 3 ? 27'h7FFFFFF : 27'd0)) begin
                    failures++;
                    $display("FAIL wrap_pc k=%0d got v=%b pc=%h", k, valid, pc);
                end
            end
            advance();
        end
        freeze = 1'b1;
        for (int i = 0; i < 6; i++) begin
            prep();
            advance();
        end
        br      = 1'b1;
        br_addr = 27'd50;
        prep();
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL branch_full_precond got cnt=%0d exp cnt=4", count);
        end
        advance();
        br = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL frozen_branch_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (k == 1) begin
                checks++;
                if (valid !== 1'b0 || count !== 3'd0) begin
                    failures++;
                    $display("FAIL frozen_flush got v=%b cnt=%0d exp v=0 cnt=0", valid, count);
                end
            end
            if (k == 3) begin
                checks++;
                if (valid !== 1'b1 || pc !== 27'd50) begin
                    failures++;
                    $display("FAIL frozen_target got v=%b pc=%h exp pc=50", valid, pc);
                end
            end
            advance();
        end
        freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL thaw_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2, 1);
        for (int k = 0; k < 5; k++) begin
            prep();
            advance();
        end
        freeze = 1'b1;
        for (int i = 0; i < 2; i++) begin
            prep();
            advance();
        end
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL mid_precond got cnt=%0d exp cnt=3", count);
        end
        rst = 1'b1;
        prep();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL mid_reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
        end
        advance();
        rst    = 1'b0;
        freeze = 1'b0;
        for (int k = 0; k < 4; k++) begin
            prep();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL mid_resume_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
            end
            if (k == 0) begin
                checks++;
                if (valid !== 1'b0 || count !== 3'd0 || imem_req !== 1'b1 || imem_addr !== PC0) begin
                    failures++;
                    $display("FAIL mid_cleared got v=%b cnt=%0d req=%b addr=%h exp v=0 cnt=0 req=1 addr=0",
                             valid, count, imem_req, imem_addr);
                end
            end
            if (k == 2) begin
                checks++;
                if (valid !== 1'b1 || pc !== PC0) begin
                    failures++;
                    $display("FAIL mid_restart got v=%b pc=%h exp v=1 pc=0", valid, pc);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int l = 1; l <= 5; l++) begin
            do_reset(2, l);
            for (int k = 0; k < 300; k++) begin
                rst     = ($urandom_range(0, 249) == 0);
                br      = ($urandom_range(0, 24) == 0);
                br_addr = ($urandom_range(0, 3) == 0) ? 27'h7FFFFFE : DW'($urandom);
                freeze  = ($urandom_range(0, 2) == 0);
                prep();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_model lat=%0d cyc=%0d got=%h exp=%h", l, cyc, obs_vec(), exp_vec());
                end
                advance();
            end
        end
        rst    = 1'b0;
        br     = 1'b0;
        freeze = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        freeze     = 1'b0;
        br         = 1'b0;
        br_addr    = '0;
        imem_valid = 1'b0;
        imem_data  = '0;
        m_fetch_pc = PC0;
        @(posedge clk);
        #1;
        test_reset_run();
        test_freeze();
        test_branch();
        test_latency();
        test_wrap_branch_freeze();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
